mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between instruction fetch (IF port) and load/store (DM port, driven by the MemRead/MemWrite controls of the MEM stage).
- Registered FSM: grants one requester, runs a req/ack handshake to memory, returns a one-cycle ready pulse, and produces the stall signals the pipeline uses to freeze IF or MEM.
- Data port has priority. A starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline ports (IF, DM), the arbiter and the unified memory.
// slave = arbiter view, master = environment view (pipeline + memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              if_stall;
  logic              dm_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, if_stall, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, if_stall, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data port wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT DM grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                i_clock,
  input  logic                i_reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int              TIMER_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]      LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t              r_state,       w_state_next;
  logic [3:0]          r_starve_cnt,  w_starve_cnt_next;
  logic [TIMER_W-1:0]  r_timer,       w_timer_next;
  logic                r_mem_req,     w_mem_req_next;
  logic                r_mem_we,      w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr,    w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata,   w_mem_wdata_next;
  logic [DATA_W-1:0]   r_if_rdata,    w_if_rdata_next;
  logic [DATA_W-1:0]   r_dm_rdata,    w_dm_rdata_next;
  logic                r_resp_dm,     w_resp_dm_next;
  logic                r_err,         w_err_next;

  logic                w_dm_any;
  logic                w_if_forced;
  logic                w_if_ready;
  logic                w_dm_ready;

  assign w_dm_any    = bus.dm_rd | bus.dm_wr;
  assign w_if_forced = bus.if_req && (r_starve_cnt == LIMIT);

  always_comb begin
    w_state_next      = r_state;
    w_starve_cnt_next = r_starve_cnt;
    w_timer_next      = r_timer;
    w_mem_req_next    = r_mem_req;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_if_rdata_next   = r_if_rdata;
    w_dm_rdata_next   = r_dm_rdata;
    w_resp_dm_next    = r_resp_dm;
    w_err_next        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_dm_any && !w_if_forced) begin
          w_state_next     = BUSY_DM;
          w_resp_dm_next   = 1'b1;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = bus.dm_wr;
          w_mem_addr_next  = bus.dm_addr;
          w_timer_next     = '0;
          if (bus.dm_wr)
            w_mem_wdata_next = bus.dm_wdata;
          // Count only DM grants that actually made fetch wait.
          if (!bus.if_req)
            w_starve_cnt_next = '0;
          else if (r_starve_cnt != LIMIT)
            w_starve_cnt_next = r_starve_cnt + 4'd1;
        end else if (bus.if_req) begin
          w_state_next      = BUSY_IF;
          w_resp_dm_next    = 1'b0;
          w_mem_req_next    = 1'b1;
          w_mem_we_next     = 1'b0;
          w_mem_addr_next   = bus.if_addr;
          w_timer_next      = '0;
          w_starve_cnt_next = '0;
        end else begin
          w_starve_cnt_next = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        w_timer_next = r_timer + 1'b1;
        if (bus.mem_ack) begin
          w_state_next   = RESP;
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 1'b0;
          if (!r_mem_we) begin
            if (r_state == BUSY_IF) w_if_rdata_next = bus.mem_rdata;
            else                    w_dm_rdata_next = bus.mem_rdata;
          end
        end else if (r_timer == TIMER_MAX) begin
          // Abort: the requester still gets its ready pulse, with zeroed read data.
          w_state_next   = RESP;
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 1'b0;
          w_err_next     = 1'b1;
          if (!r_mem_we) begin
            if (r_state == BUSY_IF) w_if_rdata_next = '0;
            else                    w_dm_rdata_next = '0;
          end
        end
      end

      RESP: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_timer      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_resp_dm    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
      r_timer      <= w_timer_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_if_rdata   <= w_if_rdata_next;
      r_dm_rdata   <= w_dm_rdata_next;
      r_resp_dm    <= w_resp_dm_next;
      r_err        <= w_err_next;
    end
  end

  assign w_if_ready = (r_state == RESP) && !r_resp_dm;
  assign w_dm_ready = (r_state == RESP) &&  r_resp_dm;

  assign bus.if_ready  = w_if_ready;
  assign bus.dm_ready  = w_dm_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_stall  = bus.if_req & ~w_if_ready;
  assign bus.dm_stall  = w_dm_any & ~w_dm_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs are checked there too.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cnt;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(64)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_mem_req",  32'(bus.mem_req),  0);
    chk("rst_mem_we",   32'(bus.mem_we),   0);
    chk("rst_mem_addr", bus.mem_addr,      0);
    chk("rst_if_ready", 32'(bus.if_ready), 0);
    chk("rst_dm_ready", 32'(bus.dm_ready), 0);
    chk("rst_err",      32'(bus.err),      0);
    chk("rst_dm_rdata", bus.dm_rdata,      0);
    rst = 1'b0;

    // IF only: grant at cycle 0, ack at cycle 3, ready at cycle 4
    @(negedge clk); bus.if_req = 1; bus.if_addr = 32'h40; #1;
    chk("if0_stall",   32'(bus.if_stall), 1);
    chk("if0_mem_req", 32'(bus.mem_req),  0);
    @(negedge clk); #1;
    chk("if1_mem_req",  32'(bus.mem_req), 1);
    chk("if1_mem_addr", bus.mem_addr,     32'h40);
    chk("if1_mem_we",   32'(bus.mem_we),  0);
    @(negedge clk); #1;
    chk("if2_stall", 32'(bus.if_stall), 1);
    @(negedge clk); bus.mem_ack = 1; bus.mem_rdata = 32'h8C220004; #1;
    chk("if3_stall",    32'(bus.if_stall), 1);
    chk("if3_if_ready", 32'(bus.if_ready), 0);
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("if4_if_ready", 32'(bus.if_ready), 1);
    chk("if4_if_rdata", bus.if_rdata,      32'h8C220004);
    chk("if4_stall",    32'(bus.if_stall), 0);
    chk("if4_mem_req",  32'(bus.mem_req),  0);
    bus.if_req = 0;
    @(negedge clk); #1;
    chk("if5_if_ready", 32'(bus.if_ready), 0);

    // Simultaneous IF + DM read: DM first, then IF
    bus.if_req = 1; bus.if_addr = 32'h44; bus.dm_rd = 1; bus.dm_addr = 32'h100; #1;
    chk("sim0_dm_stall", 32'(bus.dm_stall), 1);
    @(negedge clk); #1;
    chk("sim1_mem_addr", bus.mem_addr,              32'h100);
    chk("sim1_mem_we",   32'(bus.mem_we),           0);
    chk("sim1_starve",   32'(dut.r_starve_cnt),     1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h11112222;
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("sim2_dm_ready", 32'(bus.dm_ready), 1);
    chk("sim2_if_ready", 32'(bus.if_ready), 0);
    chk("sim2_dm_rdata", bus.dm_rdata,      32'h11112222);
    chk("sim2_dm_stall", 32'(bus.dm_stall), 0);
    bus.dm_rd = 0;
    @(negedge clk); #1;
    chk("sim3_mem_req", 32'(bus.mem_req), 0);
    @(negedge clk); #1;
    chk("sim4_mem_addr", bus.mem_addr,          32'h44);
    chk("sim4_starve",   32'(dut.r_starve_cnt), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h33334444;
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("sim5_if_ready", 32'(bus.if_ready), 1);
    chk("sim5_if_rdata", bus.if_rdata,      32'h33334444);
    bus.if_req = 0;
    @(negedge clk);

    // Starvation: four DM grants, then IF is forced through
    bus.if_req = 1; bus.if_addr = 32'h80; bus.dm_rd = 1; bus.dm_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("stv%0d_mem_addr", i), bus.mem_addr,          32'h300);
      chk($sformatf("stv%0d_starve", i),   32'(dut.r_starve_cnt), 32'(i + 1));
      bus.mem_ack = 1; bus.mem_rdata = 32'hA0000000 | 32'(i);
      @(negedge clk); bus.mem_ack = 0; #1;
      chk($sformatf("stv%0d_dm_ready", i), 32'(bus.dm_ready), 1);
      @(negedge clk);
    end
    @(negedge clk); #1;
    chk("stv4_mem_addr", bus.mem_addr,          32'h80);
    chk("stv4_starve",   32'(dut.r_starve_cnt), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("stv4_if_ready", 32'(bus.if_ready), 1);
    chk("stv4_dm_ready", 32'(bus.dm_ready), 0);
    chk("stv4_if_rdata", bus.if_rdata,      32'h12345678);
    bus.if_req = 0; bus.dm_rd = 0;
    @(negedge clk);

    // Store with dm_rd also set: write wins, dm_rdata untouched
    bus.dm_wr = 1; bus.dm_rd = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("st_mem_we",    32'(bus.mem_we), 1);
    chk("st_mem_wdata", bus.mem_wdata,   32'hCAFEF00D);
    chk("st_mem_addr",  bus.mem_addr,    32'h200);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("st_dm_ready", 32'(bus.dm_ready), 1);
    chk("st_dm_rdata", bus.dm_rdata,      32'hA0000003);
    bus.dm_wr = 0; bus.dm_rd = 0;
    @(negedge clk);

    // Timeout: no ack ever
    bus.dm_rd = 1; bus.dm_addr = 32'h400;
    @(negedge clk); #1;
    chk("to_err_early", 32'(bus.err), 0);
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk); #1;
    end
    chk("to_req_cycles", 32'(cnt),          64);
    chk("to_err",        32'(bus.err),      1);
    chk("to_dm_ready",   32'(bus.dm_ready), 1);
    chk("to_dm_rdata",   bus.dm_rdata,      0);
    bus.dm_rd = 0;
    @(negedge clk); #1;
    chk("to_err_once", 32'(bus.err), 0);

    // Reset mid-BUSY, then a late ack must be ignored
    bus.dm_rd = 1; bus.dm_addr = 32'h500;
    @(negedge clk); #1;
    chk("rb_mem_req_busy", 32'(bus.mem_req), 1);
    #1 rst = 1'b1; #1;
    chk("rb_mem_req_async", 32'(bus.mem_req), 0);
    bus.dm_rd = 0;
    @(negedge clk); rst = 1'b0; bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
    @(negedge clk); bus.mem_ack = 0; #1;
    chk("rb_dm_ready", 32'(bus.dm_ready),     0);
    chk("rb_err",      32'(bus.err),          0);
    chk("rb_mem_req",  32'(bus.mem_req),      0);
    chk("rb_state",    32'(dut.r_state),      0);
    chk("rb_dm_rdata", bus.dm_rdata,          0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
